mux_rr_arbiter: RTL and testbench

Upstream control stage for the 2:1 multiplexer (inputs A, B, select S, output Y). It arbitrates round-robin between two valid/ready input streams and drives the mux select. Each grant is held for a burst of up to BURST beats. The selected data goes through a registered, back-pressurable output slot. The downstream consumer sees one merged stream, and `sel` can be wired directly to the mux S input.

---
 rtl/mux_arb_pkg.sv | 14 +
 rtl/mux_out_reg.sv | 37 +++
 rtl/mux_rr_arbiter.sv | 74 +++++++
 tb/tb_mux_rr_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared arbiter state, select encodings and round-robin pick
package mux_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Returns SEL_B when B wins: B alone, or both valid and A was served last.
  function automatic logic rr_pick(input logic a_v, input logic b_v, input logic last);
    return b_v && (!a_v || last == SEL_A);
  endfunction

endpackage

// File: rtl/mux_out_reg.sv
// mux_out_reg: single-entry valid/ready output register for the merged stream
module mux_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A load overwrites the slot; otherwise a consumed beat empties it.
  always_comb begin
    valid_d = load_i ? 1'b1 : (valid_q && ready_i) ? 1'b0 : valid_q;
    data_d  = load_i ? data_i : data_q;
  end

  // Slot register; reset discards any held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin burst arbiter driving a 2:1 mux select and output slot
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             busy
);

  localparam int CW = BURST > 1 ? $clog2(BURST) : 1;

  arb_state_t      state_q, state_d;
  logic            sel_q, sel_d, last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            slot_free, acc, cur, cur_v, rel, pick;

  assign slot_free = !y_valid || y_ready;
  assign a_ready   = state_q == GRANT_A && slot_free;
  assign b_ready   = state_q == GRANT_B && slot_free;
  assign acc       = (a_valid && a_ready) || (b_valid && b_ready);
  assign cur       = state_q == GRANT_B ? SEL_B : SEL_A;
  assign cur_v     = cur == SEL_B ? b_valid : a_valid;
  assign rel       = state_q != IDLE && (!cur_v || (acc && cnt_q == CW'(BURST - 1)));
  assign sel       = sel_q;
  assign busy      = state_q != IDLE;

  // Arbitrate from IDLE or on release; the released channel becomes last served so the other wins ties.
  always_comb begin
    last_d  = rel ? cur : last_q;
    pick    = rr_pick(a_valid, b_valid, last_d);
    state_d = (state_q == IDLE || rel) ? (!(a_valid || b_valid) ? IDLE : pick ? GRANT_B : GRANT_A) : state_q;
    cnt_d   = rel ? '0 : acc ? cnt_q + CW'(1) : cnt_q;
    sel_d   = state_d == GRANT_B ? SEL_B : state_d == GRANT_A ? SEL_A : sel_q;
  end

  // Grant state, select, round-robin history and burst counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= SEL_A;
      last_q  <= SEL_B;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  mux_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (acc),
    .data_i  (sel_q == SEL_B ? b_data : a_data),
    .ready_i (y_ready),
    .valid_o (y_valid),
    .data_o  (y_data)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: vector table, corner sequences and random run against a transaction model
module tb_mux_rr_arbiter;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       a_valid = 0, b_valid = 0, y_ready = 0;
  logic [7:0] a_data = 0, b_data = 0;
  logic       ar[2], br[2], sl[2], yv[2], bz[2];
  logic [7:0] yd[2];
  int         n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(8), .BURST(4)) u4 (
    .clk(clk), .rst_n(rst_n), .a_valid(a_valid), .a_data(a_data), .a_ready(ar[0]),
    .b_valid(b_valid), .b_data(b_data), .b_ready(br[0]), .sel(sl[0]),
    .y_valid(yv[0]), .y_data(yd[0]), .y_ready(y_ready), .busy(bz[0]));

  mux_rr_arbiter #(.WIDTH(8), .BURST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .a_valid(a_valid), .a_data(a_data), .a_ready(ar[1]),
    .b_valid(b_valid), .b_data(b_data), .b_ready(br[1]), .sel(sl[1]),
    .y_valid(yv[1]), .y_data(yd[1]), .y_ready(y_ready), .busy(bz[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: owner (-1 none, 0 A, 1 B), beats in current burst, last served.
  typedef struct packed {
    int         g;
    int         cnt;
    int         last;
    int         sel;
    logic       yv;
    logic [7:0] yd;
  } mst_t;

  localparam mst_t M_RST = '{g: -1, cnt: 0, last: 1, sel: 0, yv: 1'b0, yd: 8'h00};
  mst_t m[2];

  function automatic mst_t step(input mst_t s, input int burst, input logic av, input logic bv,
                                input logic [7:0] ad, input logic [7:0] bd, input logic yr);
    mst_t n = s;
    logic acc, cv, ov;
    int beats;
    acc = s.g >= 0 && (!s.yv || yr) && (s.g == 0 ? av : bv);
    if (acc) begin
      n.yv = 1'b1;
      n.yd = s.g == 0 ? ad : bd;
    end else if (s.yv && yr) n.yv = 1'b0;
    if (s.g < 0) n.g = (av && bv) ? 1 - s.last : av ? 0 : bv ? 1 : -1;
    else begin
      cv = s.g == 0 ? av : bv;
      ov = s.g == 0 ? bv : av;
      beats = s.cnt + (acc ? 1 : 0);
      if (!cv || beats == burst) begin
        n.last = s.g;
        n.cnt = 0;
        n.g = ov ? 1 - s.g : cv ? s.g : -1;
      end else n.cnt = beats;
    end
    if (n.g >= 0) n.sel = n.g;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= M_RST;
      m[1] <= M_RST;
    end else begin
      m[0] <= step(m[0], 4, a_valid, b_valid, a_data, b_data, y_ready);
      m[1] <= step(m[1], 1, a_valid, b_valid, a_data, b_data, y_ready);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model%0d a_ready", i), 32'(ar[i]), 32'(m[i].g == 0 && (!m[i].yv || y_ready)));
        chk($sformatf("model%0d b_ready", i), 32'(br[i]), 32'(m[i].g == 1 && (!m[i].yv || y_ready)));
        chk($sformatf("model%0d sel", i), 32'(sl[i]), 32'(m[i].sel));
        chk($sformatf("model%0d y_valid", i), 32'(yv[i]), 32'(m[i].yv));
        chk($sformatf("model%0d busy", i), 32'(bz[i]), 32'(m[i].g >= 0));
        if (m[i].yv) chk($sformatf("model%0d y_data", i), 32'(yd[i]), 32'(m[i].yd));
      end
    end
  end

  typedef struct {
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       yr;
    logic       ar, br, sel, yv;
    logic [7:0] yd;
    logic       busy;
  } vec_t;

  vec_t tv[14];
  logic [7:0] q4[$], q1[$];
  logic [7:0] e4[12];
  bit found;

  initial begin
    //           av ad     bv bd     yr  ar br sel yv yd     busy
    tv[0]  = '{1, 8'h11, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0};
    tv[1]  = '{1, 8'h11, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 1};
    tv[2]  = '{1, 8'h22, 0, 8'h00, 1, 1, 0, 0, 1, 8'h11, 1};
    tv[3]  = '{1, 8'h33, 0, 8'h00, 1, 1, 0, 0, 1, 8'h22, 1};
    tv[4]  = '{0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 1, 8'h33, 1};
    tv[5]  = '{0, 8'h00, 1, 8'hB1, 1, 0, 0, 0, 0, 8'h00, 0};
    tv[6]  = '{0, 8'h00, 1, 8'hB1, 1, 0, 1, 1, 0, 8'h00, 1};
    tv[7]  = '{1, 8'hA4, 1, 8'hB2, 1, 0, 1, 1, 1, 8'hB1, 1};
    tv[8]  = '{1, 8'hA4, 0, 8'h00, 1, 0, 1, 1, 1, 8'hB2, 1};
    tv[9]  = '{1, 8'hA4, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 1};
    tv[10] = '{1, 8'hA5, 0, 8'h00, 0, 0, 0, 0, 1, 8'hA4, 1};
    tv[11] = '{1, 8'hA5, 0, 8'h00, 1, 1, 0, 0, 1, 8'hA4, 1};
    tv[12] = '{0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 1, 8'hA5, 1};
    tv[13] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0};
    for (int i = 0; i < 12; i++) e4[i] = (i / 4) % 2 == 0 ? 8'hAA : 8'hBB;

    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("reset y_valid", 32'(yv[0]), 0);
    chk("reset y_data", 32'(yd[0]), 0);
    chk("reset sel", 32'(sl[0]), 0);
    chk("reset busy", 32'(bz[0]), 0);
    chk("reset a_ready", 32'(ar[0]), 0);
    chk("reset b_ready", 32'(br[0]), 0);

    for (int i = 0; i < 14; i++) begin
      a_valid = tv[i].av; a_data = tv[i].ad; b_valid = tv[i].bv; b_data = tv[i].bd; y_ready = tv[i].yr;
      @(negedge clk);
      chk($sformatf("vec%0d a_ready", i), 32'(ar[0]), 32'(tv[i].ar));
      chk($sformatf("vec%0d b_ready", i), 32'(br[0]), 32'(tv[i].br));
      chk($sformatf("vec%0d sel", i), 32'(sl[0]), 32'(tv[i].sel));
      chk($sformatf("vec%0d y_valid", i), 32'(yv[0]), 32'(tv[i].yv));
      chk($sformatf("vec%0d busy", i), 32'(bz[0]), 32'(tv[i].busy));
      if (tv[i].yv) chk($sformatf("vec%0d y_data", i), 32'(yd[0]), 32'(tv[i].yd));
      @(posedge clk);
      #1;
    end

    rst_n = 0;
    a_valid = 1; a_data = 8'hAA; b_valid = 1; b_data = 8'hBB; y_ready = 1;
    @(posedge clk);
    #1 rst_n = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (yv[0] && q4.size() < 12) q4.push_back(yd[0]);
      if (yv[1] && q1.size() < 8) q1.push_back(yd[1]);
    end
    chk("burst4 beat count", 32'(q4.size()), 12);
    chk("burst1 beat count", 32'(q1.size()), 8);
    for (int i = 0; i < q4.size(); i++) chk($sformatf("burst4 beat%0d", i), 32'(q4[i]), 32'(e4[i]));
    for (int i = 0; i < q1.size(); i++) chk($sformatf("burst1 beat%0d", i), 32'(q1[i]), i % 2 == 0 ? 32'hAA : 32'hBB);

    @(posedge clk);
    #1 a_valid = 0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("burst1 b-only b_ready", 32'(br[1]), 1);
      chk("burst1 b-only y_data", 32'(yd[1] & {8{yv[1]}}), 32'hBB);
    end

    @(posedge clk);
    #1 a_valid = 1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      found = sl[0] && yv[0];
    end
    chk("reach GRANT_B with y_valid", 32'(found), 1);
    #1 rst_n = 0;
    #1;
    chk("async reset y_valid", 32'(yv[0]), 0);
    chk("async reset sel", 32'(sl[0]), 0);
    chk("async reset busy", 32'(bz[0]), 0);
    @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    @(negedge clk);
    chk("after reset A first a_ready", 32'(ar[0]), 1);
    chk("after reset A first sel", 32'(sl[0]), 0);

    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #1;
      a_valid = $urandom_range(0, 3) != 0;
      b_valid = $urandom_range(0, 3) != 0;
      y_ready = $urandom_range(0, 3) != 0;
      a_data = 8'($urandom);
      b_data = 8'($urandom);
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
